// File: rtl/calc_entry_sequencer_if.sv
// ALU-side bus of the calculator front panel: operands and opcode out, start/done handshake.
// The sequencer is the master; the ALU datapath is the slave.
interface calc_entry_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output op_a, op_b, alu_op, alu_start,
    input  alu_done, alu_result
  );

  modport slave (
    input  op_a, op_b, alu_op, alu_start,
    output alu_done, alu_result
  );
endinterface

// File: rtl/calc_entry_sequencer.sv
// Front-panel sequencer: assembles two operands byte by byte plus an opcode from button
// pulses and switches, runs the ALU with a timeout, and holds the result for display.
module calc_entry_sequencer #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           btn_pulse,
  input  logic [7:0]           sw,
  calc_entry_sequencer_if.master alu,
  output logic [DATA_W-1:0]    result,
  output logic                 err,
  output logic                 busy,
  output logic [2:0]           state_code,
  output logic [((DATA_W/8) > 1 ? $clog2(DATA_W/8) : 1)-1:0] byte_idx
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    ENTER_OP = 3'd2,
    EXEC     = 3'd3,
    WAIT     = 3'd4,
    SHOW     = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] op_a_reg, op_a_next;
  logic [DATA_W-1:0] op_b_reg, op_b_next;
  logic [OP_W-1:0]   alu_op_reg, alu_op_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              err_reg, err_next;
  logic [IDX_W-1:0]  byte_idx_reg, byte_idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              alu_start_reg;
  logic              busy_reg;
  logic [IDX_W-1:0]  idx_inc;

  assign idx_inc = (byte_idx_reg == IDX_W'(NB - 1)) ? '0 : byte_idx_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    alu_op_next   = alu_op_reg;
    result_next   = result_reg;
    err_next      = err_reg;
    byte_idx_next = byte_idx_reg;
    cnt_next      = cnt_reg;

    // Clear outranks everything and also abandons an in-flight operation.
    if (btn_pulse[2]) begin
      state_next    = ENTER_A;
      op_a_next     = '0;
      op_b_next     = '0;
      alu_op_next   = '0;
      result_next   = '0;
      err_next      = 1'b0;
      byte_idx_next = '0;
      cnt_next      = '0;
    end else begin
      unique case (state_reg)
        ENTER_A: begin
          if (btn_pulse[1]) begin
            state_next    = ENTER_B;
            byte_idx_next = '0;
          end else if (btn_pulse[0]) begin
            op_a_next[8*byte_idx_reg +: 8] = sw;
            byte_idx_next = idx_inc;
          end
        end
        ENTER_B: begin
          if (btn_pulse[1]) begin
            state_next    = ENTER_OP;
            byte_idx_next = '0;
          end else if (btn_pulse[0]) begin
            op_b_next[8*byte_idx_reg +: 8] = sw;
            byte_idx_next = idx_inc;
          end
        end
        ENTER_OP: begin
          if (btn_pulse[3])      state_next  = EXEC;
          else if (btn_pulse[1]) state_next  = ENTER_A;
          else if (btn_pulse[0]) alu_op_next = sw[OP_W-1:0];
        end
        EXEC: begin
          state_next = WAIT;
          cnt_next   = '0;
        end
        WAIT: begin
          // A done strobe on the last allowed cycle still counts as success.
          if (alu.alu_done) begin
            result_next = alu.alu_result;
            err_next    = 1'b0;
            state_next  = SHOW;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            err_next   = 1'b1;
            state_next = SHOW;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        SHOW: begin
          if (btn_pulse[3])      state_next = EXEC;
          else if (btn_pulse[1]) state_next = ENTER_A;
        end
        default: state_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ENTER_A;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      alu_op_reg    <= '0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
      byte_idx_reg  <= '0;
      cnt_reg       <= '0;
      alu_start_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_a_reg      <= op_a_next;
      op_b_reg      <= op_b_next;
      alu_op_reg    <= alu_op_next;
      result_reg    <= result_next;
      err_reg       <= err_next;
      byte_idx_reg  <= byte_idx_next;
      cnt_reg       <= cnt_next;
      alu_start_reg <= (state_next == EXEC);
      busy_reg      <= (state_next == EXEC) || (state_next == WAIT);
    end
  end

  assign alu.op_a      = op_a_reg;
  assign alu.op_b      = op_b_reg;
  assign alu.alu_op    = alu_op_reg;
  assign alu.alu_start = alu_start_reg;
  assign result        = result_reg;
  assign err           = err_reg;
  assign busy          = busy_reg;
  assign state_code    = state_reg;
  assign byte_idx      = byte_idx_reg;
endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer: entry, full run, timeout, priority/abort,
// ignore rules and asynchronous reset, each checked against hand-computed values.
module tb_calc_entry_sequencer;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 3;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        btn_pulse = '0;
  logic [7:0]        sw = '0;
  logic [DATA_W-1:0] result;
  logic              err;
  logic              busy;
  logic [2:0]        state_code;
  logic [1:0]        byte_idx;

  int total = 0;
  int bad   = 0;

  calc_entry_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) alu_bus ();

  calc_entry_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_pulse  (btn_pulse),
    .sw         (sw),
    .alu        (alu_bus.master),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .state_code (state_code),
    .byte_idx   (byte_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic press(input logic [3:0] b, input logic [7:0] s);
    @(negedge clk);
    btn_pulse = b;
    sw        = s;
    @(negedge clk);
    btn_pulse = '0;
  endtask

  // Leaves the bench at the negedge of the first WAIT cycle (counter = 0).
  task automatic go_to_wait();
    press(4'b1000, sw);
    chk("go_start", {63'd0, alu_bus.alu_start}, 64'd1);
    chk("go_exec", {61'd0, state_code}, 64'd3);
    @(negedge clk);
    chk("go_start_off", {63'd0, alu_bus.alu_start}, 64'd0);
    chk("go_wait", {61'd0, state_code}, 64'd4);
  endtask

  task automatic alu_reply(input logic [31:0] r);
    alu_bus.alu_done   = 1'b1;
    alu_bus.alu_result = r;
    @(negedge clk);
    alu_bus.alu_done   = 1'b0;
  endtask

  initial begin
    alu_bus.alu_done   = 1'b0;
    alu_bus.alu_result = '0;
    #12;
    chk("rst_state", {61'd0, state_code}, 64'd0);
    chk("rst_op_a", {32'd0, alu_bus.op_a}, 64'd0);
    chk("rst_start", {63'd0, alu_bus.alu_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte entry with wrap
    press(4'b0001, 8'h78);
    press(4'b0001, 8'h56);
    press(4'b0001, 8'h34);
    press(4'b0001, 8'h12);
    chk("entry_a", {32'd0, alu_bus.op_a}, 64'h12345678);
    chk("entry_wrap", {62'd0, byte_idx}, 64'd0);
    press(4'b0001, 8'hAA);
    chk("entry_5th", {32'd0, alu_bus.op_a}, 64'h123456AA);
    chk("entry_idx1", {62'd0, byte_idx}, 64'd1);
    press(4'b0100, 8'h00);
    chk("clear_a", {32'd0, alu_bus.op_a}, 64'd0);

    // Full run: 1.0 + 2.0
    press(4'b0001, 8'h00); press(4'b0001, 8'h00);
    press(4'b0001, 8'h80); press(4'b0001, 8'h3F);
    press(4'b0010, 8'h00);
    chk("next_b", {61'd0, state_code}, 64'd1);
    press(4'b0001, 8'h00); press(4'b0001, 8'h00);
    press(4'b0001, 8'h00); press(4'b0001, 8'h40);
    press(4'b0010, 8'h00);
    chk("next_op", {61'd0, state_code}, 64'd2);
    press(4'b0001, 8'h01);
    chk("run_a", {32'd0, alu_bus.op_a}, 64'h3F800000);
    chk("run_b", {32'd0, alu_bus.op_b}, 64'h40000000);
    chk("run_op", {61'd0, alu_bus.alu_op}, 64'd1);
    chk("pre_go_start", {63'd0, alu_bus.alu_start}, 64'd0);
    go_to_wait();
    chk("wait_busy", {63'd0, busy}, 64'd1);
    alu_reply(32'h40400000);
    chk("run_result", {32'd0, result}, 64'h40400000);
    chk("run_show", {61'd0, state_code}, 64'd5);
    chk("run_err", {63'd0, err}, 64'd0);
    chk("run_busy_off", {63'd0, busy}, 64'd0);

    // Timeout from SHOW re-execute
    go_to_wait();
    for (int i = 0; i < TIMEOUT - 1; i++) @(negedge clk);
    chk("to_still_wait", {61'd0, state_code}, 64'd4);
    @(negedge clk);
    chk("to_show", {61'd0, state_code}, 64'd5);
    chk("to_err", {63'd0, err}, 64'd1);
    chk("to_result_kept", {32'd0, result}, 64'h40400000);

    // Done on the final WAIT cycle wins
    go_to_wait();
    chk("err_sticky", {63'd0, err}, 64'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) @(negedge clk);
    alu_reply(32'hC0000000);
    chk("last_done_err", {63'd0, err}, 64'd0);
    chk("last_done_res", {32'd0, result}, 64'hC0000000);

    // Edit and re-run path, then priority clear
    press(4'b0010, 8'h00);
    chk("show_next", {61'd0, state_code}, 64'd0);
    chk("show_keep_a", {32'd0, alu_bus.op_a}, 64'h3F800000);
    press(4'b0010, 8'h00);
    press(4'b0010, 8'h00);
    press(4'b1111, 8'h07);
    chk("prio_state", {61'd0, state_code}, 64'd0);
    chk("prio_a", {32'd0, alu_bus.op_a}, 64'd0);
    chk("prio_b", {32'd0, alu_bus.op_b}, 64'd0);
    chk("prio_op", {61'd0, alu_bus.alu_op}, 64'd0);
    chk("prio_result", {32'd0, result}, 64'd0);

    // Abort in WAIT, late done ignored
    press(4'b0010, 8'h00);
    press(4'b0010, 8'h00);
    go_to_wait();
    press(4'b0100, 8'h00);
    alu_reply(32'h12345678);
    chk("abort_state", {61'd0, state_code}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);

    // Ignore rules
    press(4'b1000, 8'h00);
    chk("ign_go_state", {61'd0, state_code}, 64'd0);
    chk("ign_go_start", {63'd0, alu_bus.alu_start}, 64'd0);
    press(4'b0001, 8'h11);
    press(4'b0010, 8'h00);
    press(4'b0010, 8'h00);
    go_to_wait();
    press(4'b0001, 8'hFF);
    chk("ign_load_a", {32'd0, alu_bus.op_a}, 64'h00000011);
    chk("ign_load_op", {61'd0, alu_bus.alu_op}, 64'd0);
    chk("ign_load_idx", {62'd0, byte_idx}, 64'd0);
    alu_reply(32'h00000055);
    chk("ign_res", {32'd0, result}, 64'h55);
    alu_reply(32'h00000099);
    chk("ign_done_res", {32'd0, result}, 64'h55);
    chk("ign_done_state", {61'd0, state_code}, 64'd5);

    // Asynchronous reset mid-WAIT, between edges
    go_to_wait();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", {61'd0, state_code}, 64'd0);
    chk("arst_a", {32'd0, alu_bus.op_a}, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    chk("arst_start", {63'd0, alu_bus.alu_start}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
